noise_seq_ctrl: RTL

NOISE_SEQ_CTRL -- requirements
Module: noise_seq_ctrl

---
 rtl/noise_seq_pkg.sv | 26 ++
 rtl/seq_step_ram.sv | 30 +++
 rtl/noise_seq_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/noise_seq_pkg.sv
// Shared types and constants for the noise-channel step sequencer.
//   state_t      : sequencer FSM states
//   step_entry_t : one step-table record, five register bytes plus duration
package noise_seq_pkg;

    localparam int NSTEPS_MAX = 16;
    localparam int DUR_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        APPLY,
        PLAY
    } state_t;

    // reg_0 occupies the MSBs, matching the host write word layout
    typedef struct packed {
        logic [7:0]       reg_0;
        logic [7:0]       reg_1;
        logic [7:0]       reg_2;
        logic [7:0]       reg_3;
        logic [7:0]       reg_4;
        logic [DUR_W-1:0] dur;
    } step_entry_t;

endpackage

// File: rtl/seq_step_ram.sv
// Step table: NSTEPS x 48-bit single-port register array.
//   i_clk   : clock
//   i_we    : write enable (write i_wdata to entry i_addr on the edge)
//   i_re    : read enable (capture entry i_addr into o_rdata on the edge)
//   i_addr  : shared read/write address
//   i_wdata : write word
//   o_rdata : registered read word
// Contents are intentionally not reset.
module seq_step_ram #(
    parameter int NSTEPS = 16
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic                      i_re,
    input  logic [$clog2(NSTEPS)-1:0] i_addr,
    input  logic [47:0]               i_wdata,
    output logic [47:0]               o_rdata
);

    logic [47:0] r_mem [NSTEPS];
    logic [47:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/noise_seq_ctrl.sv
// Noise-channel step sequencer: plays a table of register settings, each
// held for dur+1 ticks of the 8 kHz envelope strobe.
//   clk_50mhz, reset       : clock, synchronous active-high reset
//   tick_8khz              : envelope time-base strobe
//   wr_valid/wr_ready      : host step-table write handshake
//   wr_addr, wr_data       : step index and {reg_0..reg_4, dur} word
//   start, stop            : playback control pulses (stop dominates)
//   loop_en, last_step     : sequence length and wrap behaviour
//   reg_0..reg_4           : register bytes to the noise channel
//   step_idx, busy         : playback status
//   step_strobe, done      : new-step and sequence-complete pulses
module noise_seq_ctrl
    import noise_seq_pkg::*;
#(
    parameter int NSTEPS = 16
) (
    input  logic        clk_50mhz,
    input  logic        reset,
    input  logic        tick_8khz,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_addr,
    input  logic [47:0] wr_data,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    input  logic [3:0]  last_step,
    output logic [7:0]  reg_0,
    output logic [7:0]  reg_1,
    output logic [7:0]  reg_2,
    output logic [7:0]  reg_3,
    output logic [7:0]  reg_4,
    output logic [3:0]  step_idx,
    output logic        busy,
    output logic        step_strobe,
    output logic        done
);

    localparam int AW = $clog2(NSTEPS);

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_step;
    logic [3:0]         w_step_next;
    step_entry_t        r_cur;      // held registers plus the dur latch
    logic [DUR_W-1:0]   r_tick;
    logic [3:0]         w_last;
    logic               w_end;
    logic               w_we;
    logic [AW-1:0]      w_addr;
    logic [47:0]        w_rdata;
    step_entry_t        w_rd;
    step_entry_t        w_show;
    logic               w_unused_addr;

    // Only the low address bits select an entry
    assign w_unused_addr = ^wr_addr;

    // Single port: LOAD owns the address, host writes use it otherwise
    assign w_we   = wr_valid && wr_ready && !reset;
    assign w_addr = (r_state == LOAD) ? r_step[AW-1:0] : wr_addr[AW-1:0];

    seq_step_ram #(.NSTEPS(NSTEPS)) u_ram (
        .i_clk   (clk_50mhz),
        .i_we    (w_we),
        .i_re    (r_state == LOAD),
        .i_addr  (w_addr),
        .i_wdata (wr_data),
        .o_rdata (w_rdata)
    );

    assign w_rd = step_entry_t'(w_rdata);

    always_comb begin
        w_last      = ({1'b0, last_step} >= 5'(NSTEPS)) ? 4'(NSTEPS - 1) : last_step;
        w_end       = (r_state == PLAY) && tick_8khz && (r_tick == r_cur.dur);
        w_next      = r_state;
        w_step_next = r_step;
        done        = 1'b0;
        if (stop) begin
            w_next      = IDLE;
            w_step_next = '0;
        end else if (start) begin
            w_next      = LOAD;
            w_step_next = '0;
        end else begin
            case (r_state)
                LOAD:  w_next = APPLY;
                APPLY: w_next = PLAY;
                PLAY: begin
                    if (w_end) begin
                        if (r_step != w_last) begin
                            w_step_next = r_step + 4'd1;
                            w_next      = LOAD;
                        end else if (loop_en) begin
                            w_step_next = '0;
                            w_next      = LOAD;
                        end else begin
                            w_next = IDLE;
                            done   = !reset;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // In APPLY the freshly read entry is shown directly so the new values
    // appear together with step_strobe; it is latched into r_cur at the edge.
    always_comb begin
        wr_ready    = (r_state != LOAD);
        busy        = (r_state != IDLE);
        step_strobe = (r_state == APPLY);
        step_idx    = r_step;
        w_show      = step_strobe ? w_rd : r_cur;
        reg_0       = w_show.reg_0;
        reg_1       = w_show.reg_1;
        reg_2       = w_show.reg_2;
        reg_3       = w_show.reg_3;
        reg_4       = w_show.reg_4;
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_cur   <= '0;
            r_tick  <= '0;
        end else begin
            r_state <= w_next;
            r_step  <= w_step_next;
            if (stop) begin
                r_cur.reg_0 <= '0;
            end else if (r_state == APPLY) begin
                r_cur <= w_rd;
            end
            if (r_state == APPLY) begin
                r_tick <= '0;
            end else if ((r_state == PLAY) && tick_8khz && !w_end) begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

endmodule
